// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one carry segment per stage,
// optional signed saturation, status flags, valid/ready with backpressure.
module cla_addsub_pipe #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);
    localparam int GPS  = GROUPS_PER_STAGE;
    localparam int SEGW = 4 * GPS;
    localparam int NSEG = WIDTH / SEGW;

    // Bit carries into positions 0..3 of one 4-bit group.
    function automatic logic [3:0] grp_carry(
        input logic [2:0] p,
        input logic [2:0] g,
        input logic       c0
    );
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Group propagate / generate, returned as {PG, GG}.
    function automatic logic [1:0] grp_pg(
        input logic [3:0] p,
        input logic [3:0] g
    );
        logic pg;
        logic gg;
        pg = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        return {pg, gg};
    endfunction

    // One segment: returns {carry_out, sum}.
    function automatic logic [SEGW:0] seg_add(
        input logic [SEGW-1:0] a,
        input logic [SEGW-1:0] b,
        input logic            ci
    );
        logic [SEGW-1:0] p;
        logic [SEGW-1:0] g;
        logic [SEGW-1:0] s;
        logic [GPS-1:0]  gp;
        logic [GPS-1:0]  gg;
        logic [GPS:0]    gc;
        logic [3:0]      bc;
        logic            prod;
        p = a | b;
        g = a & b;
        for (int j = 0; j < GPS; j++) begin
            {gp[j], gg[j]} = grp_pg(p[4*j +: 4], g[4*j +: 4]);
        end
        // Each group carry is a flat sum of products over lower groups.
        gc[0] = ci;
        for (int j = 0; j < GPS; j++) begin
            prod = ci;
            for (int k = 0; k <= j; k++) begin
                prod = prod & gp[k];
            end
            gc[j+1] = prod;
            for (int k = 0; k <= j; k++) begin
                prod = gg[k];
                for (int m = k + 1; m <= j; m++) begin
                    prod = prod & gp[m];
                end
                gc[j+1] = gc[j+1] | prod;
            end
        end
        for (int j = 0; j < GPS; j++) begin
            bc = grp_carry(p[4*j +: 3], g[4*j +: 3], gc[j]);
            s[4*j +: 4] = a[4*j +: 4] ^ b[4*j +: 4] ^ bc;
        end
        return {gc[GPS], s};
    endfunction

    logic             vld_q [NSEG];
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];
    logic [WIDTH-1:0] sum_q [NSEG];
    logic             c_q   [NSEG];
    logic             sat_q [NSEG];

    logic             vld_d [NSEG];
    logic [WIDTH-1:0] a_d   [NSEG];
    logic [WIDTH-1:0] b_d   [NSEG];
    logic [WIDTH-1:0] sum_d [NSEG];
    logic             c_d   [NSEG];
    logic             sat_d [NSEG];

    logic [WIDTH-1:0] sum_in [NSEG];
    logic             cin    [NSEG];
    logic [SEGW:0]    seg_r  [NSEG];

    logic [WIDTH-1:0] osum_q;
    logic [WIDTH-1:0] osum_d;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             neg_q;
    logic [WIDTH-1:0] raw;
    logic             a_msb;
    logic             b_msb;
    logic             advance;

    assign out_valid = vld_q[NSEG-1];
    assign advance   = !vld_q[NSEG-1] || out_ready;
    assign in_ready  = advance;

    always_comb begin
        vld_d[0]  = in_valid;
        a_d[0]    = in_a;
        b_d[0]    = in_sub ? ~in_b : in_b;
        sat_d[0]  = in_sat;
        cin[0]    = in_sub;
        sum_in[0] = '0;
        for (int s = 1; s < NSEG; s++) begin
            vld_d[s]  = vld_q[s-1];
            a_d[s]    = a_q[s-1];
            b_d[s]    = b_q[s-1];
            sat_d[s]  = sat_q[s-1];
            cin[s]    = c_q[s-1];
            sum_in[s] = sum_q[s-1];
        end
        for (int s = 0; s < NSEG; s++) begin
            seg_r[s] = seg_add(a_d[s][s*SEGW +: SEGW],
                               b_d[s][s*SEGW +: SEGW], cin[s]);
            sum_d[s] = sum_in[s];
            sum_d[s][s*SEGW +: SEGW] = seg_r[s][SEGW-1:0];
            c_d[s]   = seg_r[s][SEGW];
        end
    end

    always_comb begin
        raw    = sum_d[NSEG-1];
        a_msb  = a_d[NSEG-1][WIDTH-1];
        b_msb  = b_d[NSEG-1][WIDTH-1];
        ovf_d  = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
        osum_d = raw;
        if (sat_d[NSEG-1] && ovf_d) begin
            osum_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '{default: 1'b0};
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            sum_q  <= '{default: '0};
            c_q    <= '{default: 1'b0};
            sat_q  <= '{default: 1'b0};
            osum_q <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance) begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            c_q   <= c_d;
            sat_q <= sat_d;
            if (vld_d[NSEG-1]) begin
                osum_q <= osum_d;
                cout_q <= c_d[NSEG-1];
                ovf_q  <= ovf_d;
                zero_q <= (osum_d == '0);
                neg_q  <= osum_d[WIDTH-1];
            end
        end
    end

    assign out_sum  = osum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
    assign out_neg  = neg_q;

endmodule
